// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
// The optional pause-sequence constants are consumed only when PS2_RX_PAUSE_EN is defined.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_PAUSE     = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_KEY = 8'h77;
  localparam int unsigned PS2_PAUSE_LEN = 7;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic par);
    return (^b) ^ par;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability counter for one asynchronous PS/2 line.
// The filtered level idles high and follows the line only after FILTER_LEN steady cycles.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int unsigned CNT_W = 8;

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synchronised line disagrees with level_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], in};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver and make/break decoder in the core clock domain.
// Define PS2_RX_PAUSE_EN to fold the E1 pause sequence into a single key event.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TO_W = 17;

  logic            clk_f;
  logic            data_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .in    (ps2_kbd_clk),
    .out   (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .reset (reset),
    .in    (ps2_kbd_data),
    .out   (data_f)
  );

  ps2_state_e      state_q;
  logic            clk_prev_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      sr_q;
  logic            par_q;
  logic [TO_W-1:0] to_cnt_q;

  logic            key_valid_q;
  logic [7:0]      key_code_q;
  logic            key_pressed_q;
  logic            key_extended_q;
  logic            frame_err_q;
  logic            rel_q;
  logic            ext_q;

  logic            fall;
  logic            expire;
  logic            stop_fall;
  logic            frame_ok;
  logic            good_c;
  logic            err_c;

  assign fall      = clk_prev_q & ~clk_f;
  assign expire    = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign stop_fall = fall && !expire && (state_q == STOP);
  assign frame_ok  = data_f & odd_parity_ok(sr_q, par_q);
  assign good_c    = stop_fall & frame_ok;
  // Expiry overrides a coincident fall; a bad start bit only occurs from IDLE.
  assign err_c     = expire
                   | (fall & (state_q == IDLE) & data_f)
                   | (stop_fall & ~frame_ok);

  // Frame deserialiser and inter-edge timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      clk_prev_q <= clk_f;
      if (expire) begin
        state_q  <= IDLE;
        to_cnt_q <= '0;
      end else begin
        if (state_q == IDLE || fall) begin
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        if (fall) begin
          case (state_q)
            IDLE: begin
              if (!data_f) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end
            end
            DATA: begin
              sr_q      <= {data_f, sr_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= PARITY;
              end
            end
            PARITY: begin
              par_q   <= data_f;
              state_q <= STOP;
            end
            STOP: begin
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef PS2_RX_PAUSE_EN
  logic [2:0] pause_cnt_q;
`endif

  // Prefix folding and key-event generation; fields hold between events.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      frame_err_q    <= 1'b0;
      rel_q          <= 1'b0;
      ext_q          <= 1'b0;
`ifdef PS2_RX_PAUSE_EN
      pause_cnt_q    <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= err_c;
      if (err_c) begin
        rel_q <= 1'b0;
        ext_q <= 1'b0;
`ifdef PS2_RX_PAUSE_EN
        pause_cnt_q <= '0;
`endif
      end else if (good_c) begin
`ifdef PS2_RX_PAUSE_EN
        if (pause_cnt_q != 3'd0) begin
          pause_cnt_q <= pause_cnt_q - 3'd1;
          if (pause_cnt_q == 3'd1) begin
            key_valid_q    <= 1'b1;
            key_code_q     <= PS2_PAUSE_KEY;
            key_pressed_q  <= 1'b1;
            key_extended_q <= 1'b1;
            rel_q          <= 1'b0;
            ext_q          <= 1'b0;
          end
        end else if (sr_q == PS2_PAUSE) begin
          pause_cnt_q <= 3'(PS2_PAUSE_LEN);
        end else
`endif
        if (sr_q == PS2_BREAK) begin
          rel_q <= 1'b1;
        end else if (sr_q == PS2_EXT) begin
          ext_q <= 1'b1;
        end else begin
          key_valid_q    <= 1'b1;
          key_code_q     <= sr_q;
          key_pressed_q  <= ~rel_q;
          key_extended_q <= ext_q;
          rel_q          <= 1'b0;
          ext_q          <= 1'b0;
        end
      end
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_pressed  = key_pressed_q;
  assign key_extended = key_extended_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx; honours PS2_RX_PAUSE_EN for the pause-sequence step.
module tb_ps2_kbd_rx;

  localparam int unsigned FILTER_LEN  = 8;
  localparam int unsigned TIMEOUT_CYC = 1000;
  localparam int unsigned HALF_BIT    = 20;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       frame_err;
  logic       busy;

  ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_clk),
    .ps2_kbd_data (ps2_data),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [9:0] ev_q[$];
  int         err_n = 0;
  int         err_cyc = 0;
  int         busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: {code, pressed, extended} per key_valid strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid) ev_q.push_back({key_code, key_pressed, key_extended});
      if (frame_err) begin
        err_n   = err_n + 1;
        err_cyc = cyc;
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  int ev_base;
  int err_base;
  int busy_base;
  int last_fall_cyc;
  logic [9:0] exp_np [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    ev_base   = ev_q.size();
    err_base  = err_n;
    busy_base = busy_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF_BIT / 2);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_clk(HALF_BIT);
    ps2_clk = 1'b1;
    wait_clk(HALF_BIT / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(1'b1);
    wait_clk(30);
  endtask

  task automatic chk_events(input string tag, input int n, input logic [9:0] first);
    chk({tag, "_count"}, 32'(ev_q.size() - ev_base), 32'(n));
    if (n > 0 && ev_q.size() > ev_base) chk({tag, "_event"}, 32'(ev_q[ev_base]), 32'(first));
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    exp_np[0] = {8'hE1, 1'b1, 1'b0};
    exp_np[1] = {8'h14, 1'b1, 1'b0};
    exp_np[2] = {8'h77, 1'b1, 1'b0};
    exp_np[3] = {8'hE1, 1'b1, 1'b0};
    exp_np[4] = {8'h14, 1'b0, 1'b0};
    exp_np[5] = {8'h77, 1'b0, 1'b0};
    wait_clk(5);
    chk("rst_outputs", {22'd0, key_valid, key_code, key_pressed, key_extended, frame_err},
        32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clk(20);

    // Plain make code, parity bit 0.
    mark();
    send_frame(8'h1C, 1'b0);
    chk_events("make_1c", 1, {8'h1C, 1'b1, 1'b0});
    chk("make_1c_err", 32'(err_n - err_base), 32'd0);
    chk("make_1c_idle", 32'(busy), 32'd0);

    // Extended break folds into one event, then a plain make.
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_events("ext_break_75", 1, {8'h75, 1'b0, 1'b1});
    mark();
    send_frame(8'h75, 1'b0);
    chk_events("make_75", 1, {8'h75, 1'b1, 1'b0});

    // Parity error then recovery.
    mark();
    send_frame(8'h1C, 1'b1);
    chk("par_err_count", 32'(err_n - err_base), 32'd1);
    chk_events("par_err_noev", 0, 10'd0);
    mark();
    send_frame(8'h1C, 1'b0);
    chk_events("after_par", 1, {8'h1C, 1'b1, 1'b0});

    // Partial frame abandoned by timeout, then a break code.
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("to_busy_mid", 32'(busy), 32'd1);
    wait_clk(TIMEOUT_CYC + 30);
    chk("to_err_count", 32'(err_n - err_base), 32'd1);
    chk("to_latency_ok", 32'((err_cyc - last_fall_cyc) >= int'(TIMEOUT_CYC) &&
                             (err_cyc - last_fall_cyc) <= int'(TIMEOUT_CYC) + 20), 32'd1);
    chk("to_busy_drop", 32'(busy), 32'd0);
    chk_events("to_noev", 0, 10'd0);
    mark();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk_events("brk_1c", 1, {8'h1C, 1'b0, 1'b0});

    // Short clock glitch while idle is filtered out.
    mark();
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(40);
    chk("glitch_busy", 32'(busy_cnt - busy_base), 32'd0);
    chk("glitch_err", 32'(err_n - err_base), 32'd0);
    chk("hold_code", 32'(key_code), 32'h1C);

    // Reset in the middle of a frame.
    mark();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    wait_clk(2);
    chk("midrst_outputs", {22'd0, key_valid, key_code, key_pressed, key_extended, frame_err},
        32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset    = 1'b0;
    ps2_data = 1'b1;
    wait_clk(20);
    mark();
    send_frame(8'h1C, 1'b0);
    chk_events("after_rst", 1, {8'h1C, 1'b1, 1'b0});
    chk("after_rst_err", 32'(err_n - err_base), 32'd0);

    // Pause sequence.
    mark();
    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h77, 1'b0);
`ifdef PS2_RX_PAUSE_EN
    chk_events("pause", 1, {8'h77, 1'b1, 1'b1});
`else
    chk("pause_count", 32'(ev_q.size() - ev_base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (ev_q.size() > ev_base + i) chk($sformatf("pause_ev%0d", i),
                                         32'(ev_q[ev_base + i]), 32'(exp_np[i]));
    end
`endif
    chk("pause_err", 32'(err_n - err_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Core-side receiver for the emulated PS/2 keyboard stream that user_io drives on ps2_kbd_clk/ps2_kbd_data.
- Synchronises and filters both lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and checks framing.
- Folds E0/F0 prefixes into one key event per make/break code.
- Feeds the machine's keyboard-matrix logic with a single-cycle event strobe in the core clock domain.

Parameters:
FILTER_LEN, 8, consecutive clk cycles a synchronised line must hold a new level before the filtered level changes (2..255).
TIMEOUT_CYC, 100000, clk cycles without a filtered ps2 clock falling edge before a partial frame is abandoned (fits 17 bits).

Ports:
clk  input  1  core clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
ps2_kbd_clk  input  1  PS/2 clock from user_io; asynchronous; idles high.
ps2_kbd_data  input  1  PS/2 data from user_io; asynchronous; changes on rising clock edges.
key_valid  output  1  one-cycle strobe; key event fields are valid.
key_code  output  8  scan code of the event (prefixes stripped).
key_pressed  output  1  1 = make, 0 = break (F0 seen).
key_extended  output  1  1 = E0 prefix seen.
frame_err  output  1  one-cycle strobe on start, parity or stop error, or timeout.
busy  output  1  1 while a frame is being received (state != IDLE).

Behaviour:
- Reset values: key_valid=0, key_code=0, key_pressed=0, key_extended=0, frame_err=0, busy=0.
- Reset also clears: FSM=IDLE, prefix flags rel/ext=0, filtered clk=1, filtered data=1, timeout counter=0.
- Line path, per line:
  - 2-flop synchroniser, then stability counter.
  - Filtered level takes the synchronised value after FILTER_LEN consecutive equal cycles.
  - Glitches shorter than FILTER_LEN are ignored.
- fall = filtered clk was 1 last cycle and is 0 this cycle. All sampling uses filtered data at fall.
- FSM states:
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1 (bad start), pulse frame_err and stay in IDLE.
  - DATA: on fall, shift data into sr[7] (sr shifts right) and increment bit_cnt. After the 8th bit go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. The frame is good if data=1 and (XOR of sr bits) XOR parity = 1 (odd). Otherwise pulse frame_err.
- Timeout: the counter runs whenever the state is not IDLE and clears on every fall. At TIMEOUT_CYC: go to IDLE, pulse frame_err, clear rel/ext.
- Decoder, acting on each good byte b, in the cycle after the STOP fall:
  - b=F0: set rel.
  - b=E0: set ext.
  - Any other byte: key_code=b, key_pressed=~rel, key_extended=ext, pulse key_valid, clear rel/ext.
- Key fields hold until the next event.
- Any frame_err clears rel/ext. No partial prefixes survive an error.
- Latency: key_valid is high exactly 1 clk after the clk in which the STOP fall is detected.
- A fall arriving in the same cycle as the timeout expiry: the timeout wins and that fall is ignored.
- reset asserted mid-frame: the frame is discarded and no strobe is issued.
- busy = (state != IDLE).

Optional Feature:
- Macro PS2_RX_PAUSE_EN.
- Defined:
  - Byte E1 starts a pause sequence. A counter swallows the next 7 good bytes (14 77 E1 F0 14 F0 77) without events.
  - After the 7th byte, emit one event: key_code=77, key_pressed=1, key_extended=1.
  - A frame_err during the sequence aborts it with no event.
- Undefined: E1 is treated as an ordinary non-prefix byte and emitted as a normal event (code E1, make).

Decomposition:
- Package ps2_pkg:
  - FSM enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_PAUSE=8'hE1, PS2_PAUSE_LEN=7.
- Sub-module ps2_line_filter:
  - Parameter FILTER_LEN, ports clk, reset, in, out.
  - Synchroniser plus stability counter; instantiated twice (clk and data).
- FSM and decoder stay in ps2_kbd_rx.

Test Plan:
- Frame 0x1C with parity 0 and a valid stop, bit period 3000 clk -> key_valid once, key_code=1C, key_pressed=1, key_extended=0; frame_err never asserted.
- Sequence E0 F0 75 -> exactly one key_valid: code 75, pressed=0, extended=1. A following plain 75 gives pressed=1, extended=0.
- Frame 0x1C with parity forced to 1 -> frame_err pulse, no key_valid. Next frame 0x1C -> normal event.
- 4 data bits of a frame, then lines idle for TIMEOUT_CYC+10 clk -> frame_err at cycle TIMEOUT_CYC, busy drops. F0 1C afterwards -> code 1C, pressed=0.
- 3-clk low glitch on ps2_kbd_clk with FILTER_LEN=8 while idle -> no state change, busy stays 0. Reset asserted mid-frame -> all outputs 0 and the next frame decodes correctly.
- E1 14 77 E1 F0 14 F0 77:
  - With PS2_RX_PAUSE_EN: single event code 77, pressed=1, extended=1.
  - Without it: events E1(make), 14(make), 77(make), E1(make), 14(break), 77(break).
